// File: rtl/mmu_pkg.sv
// Shared defaults, saturation limits and overflow classification for the MMU
// processing elements.
package mmu_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ACC_W  = 16;
    localparam int unsigned MAX_ACC_W  = 64;

    typedef logic [MAX_ACC_W:0] wide_t;

    typedef enum logic [1:0] {
        OVF_NONE = 2'd0,
        OVF_HIGH = 2'd1,
        OVF_LOW  = 2'd2
    } ovf_kind_e;

    function automatic bit acc_w_ok(input int unsigned data_w, input int unsigned acc_w);
        return (acc_w >= 2 * data_w) && (acc_w <= MAX_ACC_W) && (data_w > 0);
    endfunction

    function automatic wide_t sat_max(input int unsigned acc_w, input bit sgn);
        wide_t one;
        one = wide_t'(1);
        if (sgn) begin
            return (one << (acc_w - 1)) - one;
        end
        return (one << acc_w) - one;
    endfunction

    // Only the low acc_w bits are meaningful; the signed minimum is 1 followed by zeros.
    function automatic wide_t sat_min(input int unsigned acc_w, input bit sgn);
        wide_t one;
        one = wide_t'(1);
        if (sgn) begin
            return one << (acc_w - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mmu_mac.sv
// Combinational multiply-accumulate with overflow detection and optional
// clamping; the sum is formed one bit wider than the accumulator.
module mmu_mac
    import mmu_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter bit          SIGNED   = 1'b0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] weight,
    input  logic [ACC_W-1:0]  sum,
    output logic [ACC_W-1:0]  result,
    output logic              ovf_hit
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W, SIGNED));

    logic [PW-1:0]    a_x;
    logic [PW-1:0]    b_x;
    logic [PW-1:0]    prod;
    logic [ACC_W:0]   prod_e;
    logic [ACC_W:0]   sum_e;
    logic [ACC_W:0]   total;
    ovf_kind_e        kind;

    always_comb begin
        // Extending operands to the product width keeps the low PW bits of the
        // product exact for both signed and unsigned operands.
        a_x    = {{DATA_W{SIGNED & data[DATA_W-1]}}, data};
        b_x    = {{DATA_W{SIGNED & weight[DATA_W-1]}}, weight};
        prod   = a_x * b_x;
        prod_e = {{(ACC_W + 1 - PW){SIGNED & prod[PW-1]}}, prod};
        sum_e  = {SIGNED & sum[ACC_W-1], sum};
        total  = prod_e + sum_e;

        kind = OVF_NONE;
        if (SIGNED) begin
            if (total[ACC_W] != total[ACC_W-1]) begin
                kind = total[ACC_W] ? OVF_LOW : OVF_HIGH;
            end
        end else if (total[ACC_W]) begin
            kind = OVF_HIGH;
        end

        ovf_hit = (kind != OVF_NONE);
        result  = total[ACC_W-1:0];
        if (SATURATE) begin
            case (kind)
                OVF_HIGH: result = MAX_V;
                OVF_LOW:  result = MIN_V;
                default:  result = total[ACC_W-1:0];
            endcase
        end
    end

endmodule

// File: rtl/mmu_pe_dbuf.sv
// Systolic MMU processing element with a shadow weight chain; a swap wavefront
// commits the shadow weight without draining the pipeline.
module mmu_pe_dbuf
    import mmu_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter bit          SIGNED   = 1'b0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              active_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ACC_W-1:0]  sum_in,
    input  logic              wload_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              wswap_in,
    output logic              active_out,
    output logic [DATA_W-1:0] data_out,
    output logic [ACC_W-1:0]  sum_out,
    output logic              wload_out,
    output logic [DATA_W-1:0] w_out,
    output logic              wswap_out,
    output logic              ovf
);

    if (!acc_w_ok(DATA_W, ACC_W)) begin : g_acc_w_check
        $error("mmu_pe_dbuf: ACC_W must be >= 2*DATA_W and <= 64");
    end

    logic [DATA_W-1:0] weight;
    logic [DATA_W-1:0] shadow;
    logic              shadow_vld;
    logic [ACC_W-1:0]  mac_result;
    logic              mac_ovf;
    logic              do_swap;

    mmu_mac #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_mac (
        .data    (data_in),
        .weight  (weight),
        .sum     (sum_in),
        .result  (mac_result),
        .ovf_hit (mac_ovf)
    );

    always_comb begin
        do_swap = wswap_in && shadow_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_out <= 1'b0;
            data_out   <= '0;
            sum_out    <= '0;
            wload_out  <= 1'b0;
            w_out      <= '0;
            wswap_out  <= 1'b0;
            ovf        <= 1'b0;
            weight     <= '0;
            shadow     <= '0;
            shadow_vld <= 1'b0;
        end else if (!stall) begin
            active_out <= active_in;
            if (active_in) begin
                data_out <= data_in;
                sum_out  <= mac_result;
                if (mac_ovf) begin
                    ovf <= 1'b1;
                end
            end else begin
                data_out <= '0;
                sum_out  <= '0;
            end

            wload_out <= wload_in;
            if (wload_in) begin
                shadow <= w_in;
                w_out  <= shadow;
            end else begin
                w_out  <= '0;
            end

            // The MAC above already used the pre-swap weight, and a same-cycle
            // load keeps the chain valid because the new shadow arrives with it.
            wswap_out <= wswap_in;
            if (do_swap) begin
                weight <= shadow;
            end
            if (wload_in) begin
                shadow_vld <= 1'b1;
            end else if (do_swap) begin
                shadow_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_pe_dbuf.sv
// Directed bench for mmu_pe_dbuf: four parameter variants share one stimulus
// stream, plus a three-PE column exercising the shadow chain and swap wavefront.
module tb_mmu_pe_dbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, act, wl, ws;
    logic [7:0]  din, win;
    logic [15:0] sin;

    logic        uns_ao, uns_wlo, uns_wso, uns_ovf;
    logic [7:0]  uns_do, uns_wo;
    logic [15:0] uns_so;
    logic        sgn_ao, sgn_wlo, sgn_wso, sgn_ovf;
    logic [7:0]  sgn_do, sgn_wo;
    logic [15:0] sgn_so;
    logic        sat_ao, sat_wlo, sat_wso, sat_ovf;
    logic [7:0]  sat_do, sat_wo;
    logic [15:0] sat_so;
    logic        ss_ao, ss_wlo, ss_wso, ss_ovf;
    logic [7:0]  ss_do, ss_wo;
    logic [15:0] ss_so;

    mmu_pe_dbuf u_uns (
        .clk(clk), .reset(reset), .stall(stall), .active_in(act), .data_in(din),
        .sum_in(sin), .wload_in(wl), .w_in(win), .wswap_in(ws),
        .active_out(uns_ao), .data_out(uns_do), .sum_out(uns_so), .wload_out(uns_wlo),
        .w_out(uns_wo), .wswap_out(uns_wso), .ovf(uns_ovf)
    );

    mmu_pe_dbuf #(.SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .stall(stall), .active_in(act), .data_in(din),
        .sum_in(sin), .wload_in(wl), .w_in(win), .wswap_in(ws),
        .active_out(sgn_ao), .data_out(sgn_do), .sum_out(sgn_so), .wload_out(sgn_wlo),
        .w_out(sgn_wo), .wswap_out(sgn_wso), .ovf(sgn_ovf)
    );

    mmu_pe_dbuf #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .stall(stall), .active_in(act), .data_in(din),
        .sum_in(sin), .wload_in(wl), .w_in(win), .wswap_in(ws),
        .active_out(sat_ao), .data_out(sat_do), .sum_out(sat_so), .wload_out(sat_wlo),
        .w_out(sat_wo), .wswap_out(sat_wso), .ovf(sat_ovf)
    );

    mmu_pe_dbuf #(.SIGNED(1'b1), .SATURATE(1'b1)) u_ss (
        .clk(clk), .reset(reset), .stall(stall), .active_in(act), .data_in(din),
        .sum_in(sin), .wload_in(wl), .w_in(win), .wswap_in(ws),
        .active_out(ss_ao), .data_out(ss_do), .sum_out(ss_so), .wload_out(ss_wlo),
        .w_out(ss_wo), .wswap_out(ss_wso), .ovf(ss_ovf)
    );

    // Three-PE column: weight chain flows top (c0) to bottom (c2).
    logic        c_wl, c_ws;
    logic [7:0]  c_win;
    logic        c0_ao, c1_ao, c2_ao, c0_wlo, c1_wlo, c2_wlo;
    logic        c0_wso, c1_wso, c2_wso, c0_ovf, c1_ovf, c2_ovf;
    logic [7:0]  c0_do, c1_do, c2_do, c0_wo, c1_wo, c2_wo;
    logic [15:0] c0_so, c1_so, c2_so;

    mmu_pe_dbuf c0 (
        .clk(clk), .reset(reset), .stall(1'b0), .active_in(1'b0), .data_in(8'h00),
        .sum_in(16'h0000), .wload_in(c_wl), .w_in(c_win), .wswap_in(c_ws),
        .active_out(c0_ao), .data_out(c0_do), .sum_out(c0_so), .wload_out(c0_wlo),
        .w_out(c0_wo), .wswap_out(c0_wso), .ovf(c0_ovf)
    );

    mmu_pe_dbuf c1 (
        .clk(clk), .reset(reset), .stall(1'b0), .active_in(1'b0), .data_in(8'h00),
        .sum_in(c0_so), .wload_in(c0_wlo), .w_in(c0_wo), .wswap_in(c0_wso),
        .active_out(c1_ao), .data_out(c1_do), .sum_out(c1_so), .wload_out(c1_wlo),
        .w_out(c1_wo), .wswap_out(c1_wso), .ovf(c1_ovf)
    );

    mmu_pe_dbuf c2 (
        .clk(clk), .reset(reset), .stall(1'b0), .active_in(1'b0), .data_in(8'h00),
        .sum_in(c1_so), .wload_in(c1_wlo), .w_in(c1_wo), .wswap_in(c1_wso),
        .active_out(c2_ao), .data_out(c2_do), .sum_out(c2_so), .wload_out(c2_wlo),
        .w_out(c2_wo), .wswap_out(c2_wso), .ovf(c2_ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; act = 1'b0; wl = 1'b0; ws = 1'b0;
        din = 8'h00; win = 8'h00; sin = 16'h0000;
        c_wl = 1'b0; c_ws = 1'b0; c_win = 8'h00;
        cyc();
        chk("rst_active", uns_ao, 0);
        chk("rst_data", uns_do, 0);
        chk("rst_sum", uns_so, 0);
        chk("rst_wload", uns_wlo, 0);
        chk("rst_wout", uns_wo, 0);
        chk("rst_wswap", uns_wso, 0);
        chk("rst_ovf", uns_ovf, 0);
        reset = 1'b0;

        // Unsigned basic: weight 3, 5*3+10
        wl = 1'b1; win = 8'd3; cyc();
        chk("ld3_wload_out", uns_wlo, 1);
        chk("ld3_w_out_old", uns_wo, 0);
        wl = 1'b0; ws = 1'b1; cyc();
        chk("swap_pulse", uns_wso, 1);
        ws = 1'b0; act = 1'b1; din = 8'd5; sin = 16'd10; cyc();
        chk("uns_mac", uns_so, 16'd25);
        chk("uns_data", uns_do, 8'd5);
        chk("uns_active", uns_ao, 1);
        act = 1'b0; cyc();
        chk("bubble_sum", uns_so, 0);
        chk("bubble_data", uns_do, 0);

        // Signed: weight -2, 7*-2+4 = -10
        wl = 1'b1; win = 8'hFE; cyc();
        chk("ld_fe_w_out_old", uns_wo, 8'd3);
        wl = 1'b0; ws = 1'b1; cyc();
        ws = 1'b0; act = 1'b1; din = 8'd7; sin = 16'd4; cyc();
        chk("sgn_mac", sgn_so, 16'hFFF6);
        chk("sgn_ovf_clear", sgn_ovf, 0);
        chk("uns_mac_254", uns_so, 16'h06F6);

        // Overflow: weight 0xFF, 255*255 + 0xFFFF
        act = 1'b0; wl = 1'b1; win = 8'hFF; cyc();
        wl = 1'b0; ws = 1'b1; cyc();
        ws = 1'b0; act = 1'b1; din = 8'hFF; sin = 16'hFFFF; cyc();
        chk("sat_clamp_max", sat_so, 16'hFFFF);
        chk("sat_ovf", sat_ovf, 1);
        chk("wrap_sum", uns_so, 16'hFE00);
        chk("wrap_ovf", uns_ovf, 1);
        chk("sgn_neg1_sq", sgn_so, 16'h0000);
        chk("sgn_no_ovf", sgn_ovf, 0);
        din = 8'h80; sin = 16'h7FFF; cyc();
        chk("sgn_pos_wrap", sgn_so, 16'h807F);
        chk("sgn_pos_ovf", sgn_ovf, 1);
        chk("ss_clamp_max", ss_so, 16'h7FFF);
        chk("uns_no_carry", sat_so, 16'hFF7F);
        din = 8'h7F; sin = 16'h8000; cyc();
        chk("sgn_neg_wrap", sgn_so, 16'h7F81);
        chk("ss_clamp_min", ss_so, 16'h8000);
        chk("ss_ovf", ss_ovf, 1);
        act = 1'b0; cyc();
        chk("ovf_sticky", uns_ovf, 1);
        chk("ovf_sticky_bubble_sum", uns_so, 0);
        reset = 1'b1; cyc();
        reset = 1'b0;
        chk("ovf_reset", uns_ovf, 0);
        chk("ovf_reset_sgn", sgn_ovf, 0);

        // Double buffer: weight 2 active while shadow 9 loads
        wl = 1'b1; win = 8'd2; cyc();
        wl = 1'b0; ws = 1'b1; cyc();
        ws = 1'b0; act = 1'b1; sin = 16'd0; din = 8'd1; wl = 1'b1; win = 8'd9; cyc();
        chk("db_sum1", uns_so, 16'd2);
        wl = 1'b0; din = 8'd2; cyc();
        chk("db_sum2", uns_so, 16'd4);
        din = 8'd3; cyc();
        chk("db_sum3", uns_so, 16'd6);
        din = 8'd4; ws = 1'b1; cyc();
        chk("db_sum4_preswap", uns_so, 16'd8);
        din = 8'd1; ws = 1'b0; cyc();
        chk("db_new_weight", uns_so, 16'd9);

        // Swap with no valid shadow is ignored
        ws = 1'b1; din = 8'd1; cyc();
        chk("noswap_sum", uns_so, 16'd9);
        chk("noswap_pulse", uns_wso, 1);
        ws = 1'b0; cyc();
        chk("noswap_hold", uns_so, 16'd9);

        // Same-cycle load and swap
        act = 1'b0; wl = 1'b1; win = 8'd4; cyc();
        win = 8'd6; ws = 1'b1; cyc();
        chk("ldswap_w_out", uns_wo, 8'd4);
        wl = 1'b0; ws = 1'b0; act = 1'b1; din = 8'd1; cyc();
        chk("ldswap_weight", uns_so, 16'd4);
        ws = 1'b1; cyc();
        chk("ldswap_vld_kept_pre", uns_so, 16'd4);
        ws = 1'b0; cyc();
        chk("ldswap_vld_kept_post", uns_so, 16'd6);

        // Stall freezes everything
        din = 8'd3; sin = 16'd1; cyc();
        chk("pre_stall_sum", uns_so, 16'd19);
        stall = 1'b1; din = 8'd7; sin = 16'd0; wl = 1'b1; win = 8'd1; ws = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_sum", uns_so, 16'd19);
            chk("stall_data", uns_do, 8'd3);
            chk("stall_wload", uns_wlo, 0);
            chk("stall_wswap", uns_wso, 0);
        end
        stall = 1'b0; wl = 1'b0; ws = 1'b0; din = 8'd2; sin = 16'd0; cyc();
        chk("post_stall_weight", uns_so, 16'd12);
        chk("post_stall_w_out", uns_wo, 0);
        stall = 1'b1; reset = 1'b1; cyc();
        chk("rst_in_stall_sum", uns_so, 0);
        chk("rst_in_stall_data", uns_do, 0);
        chk("rst_in_stall_active", uns_ao, 0);
        reset = 1'b0; stall = 1'b0; din = 8'd5; cyc();
        chk("rst_weight_cleared", uns_so, 0);
        act = 1'b0;

        // Three-PE column load and swap wavefront
        c_wl = 1'b1; c_win = 8'd7; cyc();
        c_win = 8'd8; cyc();
        c_win = 8'd9; cyc();
        c_wl = 1'b0; cyc();
        cyc();
        chk("chain_shadow0", c0.shadow, 8'd9);
        chk("chain_shadow1", c1.shadow, 8'd8);
        chk("chain_shadow2", c2.shadow, 8'd7);
        c_ws = 1'b1; cyc();
        c_ws = 1'b0; cyc();
        cyc();
        chk("chain_swap_bottom", c2_wso, 1);
        cyc();
        chk("chain_weight0", c0.weight, 8'd9);
        chk("chain_weight1", c1.weight, 8'd8);
        chk("chain_weight2", c2.weight, 8'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
